// File: rtl/vid_pixel_pipe.sv
// rtl/vid_pixel_pipe.sv - programmable raster timing generator fed by a parametrised RGB pixel FIFO
module vid_pixel_pipe #(
    parameter int CW     = 8,
    parameter int DEPTH  = 16,
    parameter int THRESH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    input  logic                   pix_valid,
    input  logic [3*CW-1:0]        pix_data,
    output logic                   pix_ready,
    output logic                   fetch_req,
    output logic [$clog2(DEPTH):0] level,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   hblank,
    output logic                   vblank,
    output logic                   de,
    output logic [CW-1:0]          R,
    output logic [CW-1:0]          G,
    output logic [CW-1:0]          B,
    output logic                   underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] THR_LVL  = LW'(THRESH);

    typedef enum logic {OFF, RUN} state_t;
    state_t state;

    logic        en;
    logic [5:0]  pdiv;
    logic [12:0] hsize, hend, hs_start, hs_end;
    logic [12:0] vsize, vend, vs_start, vs_end;
    logic [5:0]  pcnt;
    logic [12:0] hcnt, vcnt;

    logic cr_wr, en_nxt, tick, h_wrap, frame_wrap;
    logic hb_d, vb_d, hs_d, vs_d, de_d;
    logic push, pop, flush, empty;
    logic cfg_unused;

    logic [3*CW-1:0] mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;

    // The FSM follows the value en is about to take, so RUN starts the cycle after the CR write.
    assign cr_wr      = cfg_we && (cfg_addr == 3'd0);
    assign en_nxt     = cr_wr ? cfg_wdata[0] : en;
    assign tick       = (state == RUN) && (pcnt == pdiv);
    assign h_wrap     = (hcnt == hend);
    assign frame_wrap = tick && h_wrap && (vcnt == vend);

    assign hb_d = (hcnt >= hsize);
    assign vb_d = (vcnt >= vsize);
    assign hs_d = (hcnt >= hs_start) && (hcnt < hs_end);
    assign vs_d = (vcnt >= vs_start) && (vcnt < vs_end);
    assign de_d = !hb_d && !vb_d;

    assign empty     = (level == '0);
    assign pix_ready = (level != FULL_LVL);
    assign fetch_req = en && (level < THR_LVL);
    assign push      = pix_valid && pix_ready;
    assign pop       = tick && de_d && !empty;
    assign flush     = (en && !en_nxt) || frame_wrap;

    assign cfg_unused = ^cfg_wdata[31:26];

    always_ff @(posedge clk) begin
        if (reset) begin
            en       <= 1'b0;
            pdiv     <= '0;
            hsize    <= '0;
            hend     <= '0;
            hs_start <= '0;
            hs_end   <= '0;
            vsize    <= '0;
            vend     <= '0;
            vs_start <= '0;
            vs_end   <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0: begin
                    en   <= cfg_wdata[0];
                    pdiv <= cfg_wdata[6:1];
                end
                3'd1: if (!en) begin
                    hsize <= cfg_wdata[25:13];
                    hend  <= cfg_wdata[12:0];
                end
                3'd2: if (!en) begin
                    hs_start <= cfg_wdata[25:13];
                    hs_end   <= cfg_wdata[12:0];
                end
                3'd3: if (!en) begin
                    vsize <= cfg_wdata[25:13];
                    vend  <= cfg_wdata[12:0];
                end
                3'd4: if (!en) begin
                    vs_start <= cfg_wdata[25:13];
                    vs_end   <= cfg_wdata[12:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= OFF;
            pcnt      <= '0;
            hcnt      <= '0;
            vcnt      <= '0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            de        <= 1'b0;
            hblank    <= 1'b1;
            vblank    <= 1'b1;
            {R, G, B} <= '0;
            underflow <= 1'b0;
        end else begin
            if (cr_wr)
                underflow <= 1'b0;
            else if (tick && de_d && empty)
                underflow <= 1'b1;

            case (state)
                OFF: begin
                    pcnt      <= '0;
                    hcnt      <= '0;
                    vcnt      <= '0;
                    hsync     <= 1'b0;
                    vsync     <= 1'b0;
                    de        <= 1'b0;
                    hblank    <= 1'b1;
                    vblank    <= 1'b1;
                    {R, G, B} <= '0;
                    if (en_nxt)
                        state <= RUN;
                end
                RUN: begin
                    if (!en_nxt) begin
                        state     <= OFF;
                        pcnt      <= '0;
                        hcnt      <= '0;
                        vcnt      <= '0;
                        hsync     <= 1'b0;
                        vsync     <= 1'b0;
                        de        <= 1'b0;
                        hblank    <= 1'b1;
                        vblank    <= 1'b1;
                        {R, G, B} <= '0;
                    end else if (tick) begin
                        pcnt   <= '0;
                        hcnt   <= h_wrap ? 13'd0 : hcnt + 13'd1;
                        if (h_wrap)
                            vcnt <= (vcnt == vend) ? 13'd0 : vcnt + 13'd1;
                        hblank <= hb_d;
                        vblank <= vb_d;
                        hsync  <= hs_d;
                        vsync  <= vs_d;
                        de     <= de_d;
                        {R, G, B} <= pop ? mem[rptr] : '0;
                    end else begin
                        pcnt <= pcnt + 6'd1;
                    end
                end
                default: state <= OFF;
            endcase
        end
    end

    // A flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wptr] <= pix_data;
    end

endmodule

// File: tb/tb_vid_pixel_pipe.sv
// tb/tb_vid_pixel_pipe.sv - self-checking bench for vid_pixel_pipe against a frame-arithmetic and queue model
module tb_vid_pixel_pipe;
    localparam int CW     = 8;
    localparam int DEPTH  = 16;
    localparam int THRESH = 8;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           cfg_we = 1'b0;
    logic [2:0]     cfg_addr = 3'd0;
    logic [31:0]    cfg_wdata = 32'd0;
    logic           pix_valid = 1'b0;
    logic [23:0]    pix_data = 24'd0;
    logic           pix_ready, fetch_req;
    logic [LW-1:0]  level;
    logic           hsync, vsync, hblank, vblank, de, underflow;
    logic [CW-1:0]  R, G, B;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    vid_pixel_pipe #(.CW(CW), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready), .fetch_req(fetch_req),
        .level(level), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de),
        .R(R), .G(G), .B(B), .underflow(underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pk(input int a, input int b);
        return 32'((a << 13) | b);
    endfunction

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d, output int n);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d; n = cyc;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1; cfg_we = 1'b0; pix_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic prefill16();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            pix_valid = 1'b1;
            pix_data = 24'h010203 + 24'(i) * 24'h010101;
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hsync, vsync, de, hblank, vblank} !== 5'b00011) begin
            errors++; $display("FAIL reset_raster got=%b exp=00011", {hsync, vsync, de, hblank, vblank});
        end
        checks++;
        if ({R, G, B} !== 24'h0) begin errors++; $display("FAIL reset_rgb got=%h exp=0", {R, G, B}); end
        checks++;
        if ({underflow, pix_ready, fetch_req} !== 3'b010) begin
            errors++; $display("FAIL reset_flags got=%b exp=010", {underflow, pix_ready, fetch_req});
        end
        checks++;
        if (level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        reset = 1'b0;
    endtask

    task automatic test_raster();
        int n, c, m, j, h, v, de_cnt, hs_cnt, hs_first, vs_cnt;
        logic [4:0] e_t;
        cfg_write(3'd1, pk(8, 14), n);
        cfg_write(3'd2, pk(10, 13), n);
        cfg_write(3'd3, pk(4, 9), n);
        cfg_write(3'd4, pk(6, 7), n);
        cfg_write(3'd0, 32'h8, n);
        cfg_write(3'd0, 32'h9, n);
        de_cnt = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            c = cyc;
            m = c - (n + 6);
            if (m < 0) begin
                e_t = 5'b00011;
            end else begin
                j = m / 5; h = j % 15; v = (j / 15) % 10;
                e_t = {(h >= 10 && h < 13), (v >= 6 && v < 7), (h < 8 && v < 4), (h >= 8), (v >= 4)};
            end
            checks++;
            if ({hsync, vsync, de, hblank, vblank} !== e_t) begin
                errors++; $display("FAIL raster_outputs cyc=%0d got=%b exp=%b", c, {hsync, vsync, de, hblank, vblank}, e_t);
            end
            checks++;
            if ({R, G, B} !== 24'h0) begin errors++; $display("FAIL raster_rgb_empty cyc=%0d got=%h exp=0", c, {R, G, B}); end
            checks++;
            if (underflow !== (m >= 0)) begin
                errors++; $display("FAIL raster_underflow cyc=%0d got=%b exp=%b", c, underflow, (m >= 0));
            end
            checks++;
            if (fetch_req !== 1'b1) begin errors++; $display("FAIL raster_fetch_req cyc=%0d got=%b exp=1", c, fetch_req); end
            if (m >= 0 && m < 75) begin
                if (de) de_cnt++;
                if (hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = m;
                end
            end
            if (m >= 0 && m < 750 && vsync) vs_cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (de_cnt != 40) begin errors++; $display("FAIL line_de_clocks got=%0d exp=40", de_cnt); end
        checks++;
        if (hs_cnt != 15) begin errors++; $display("FAIL line_hsync_clocks got=%0d exp=15", hs_cnt); end
        checks++;
        if (hs_first != 50) begin errors++; $display("FAIL hsync_offset got=%0d exp=50", hs_first); end
        checks++;
        if (vs_cnt != 75) begin errors++; $display("FAIL frame_vsync_clocks got=%0d exp=75", vs_cnt); end
    endtask

    task automatic test_underflow_clear();
        int n;
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_before_clear got=%b exp=1", underflow); end
        cfg_write(3'd0, 32'h8, n);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_cleared k=%0d got=%b exp=0", k, underflow); end
            checks++;
            if ({hsync, vsync, de, hblank, vblank, fetch_req} !== 6'b000110) begin
                errors++; $display("FAIL off_outputs k=%0d got=%b exp=000110", k, {hsync, vsync, de, hblank, vblank, fetch_req});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_datapath();
        int n, c, j, h, v, lvl_before, e_lvl;
        logic [23:0] q[$];
        logic [23:0] e_rgb;
        logic e_uf, e_de, de_t, flush, seen_first;
        pulse_reset();
        cfg_write(3'd1, pk(8, 9), n);
        cfg_write(3'd3, pk(4, 5), n);
        q.delete();
        for (int i = 0; i < 16; i++) q.push_back(24'h010203 + 24'(i) * 24'h010101);
        prefill16();
        checks++;
        if (level !== LW'(16) || pix_ready !== 1'b0) begin
            errors++; $display("FAIL prefill_level got=%0d/%b exp=16/0", level, pix_ready);
        end
        cfg_write(3'd0, 32'h1, n);
        e_rgb = 24'h0; e_uf = 1'b0; e_de = 1'b0; e_lvl = 16; seen_first = 1'b0;
        for (int k = 0; k < 200; k++) begin
            c = cyc;
            checks++;
            if ({R, G, B} !== e_rgb) begin errors++; $display("FAIL dp_rgb cyc=%0d got=%h exp=%h", c, {R, G, B}, e_rgb); end
            checks++;
            if (level !== LW'(e_lvl)) begin errors++; $display("FAIL dp_level cyc=%0d got=%0d exp=%0d", c, level, e_lvl); end
            checks++;
            if (underflow !== e_uf) begin errors++; $display("FAIL dp_underflow cyc=%0d got=%b exp=%b", c, underflow, e_uf); end
            checks++;
            if (de !== e_de) begin errors++; $display("FAIL dp_de cyc=%0d got=%b exp=%b", c, de, e_de); end
            if (e_de && !seen_first) begin
                seen_first = 1'b1;
                checks++;
                if ({R, G, B} !== 24'h010203) begin errors++; $display("FAIL first_pixel got=%h exp=010203", {R, G, B}); end
            end
            if (k < 20) begin
                checks++;
                if (underflow !== 1'b0) begin errors++; $display("FAIL early_underflow cyc=%0d got=%b exp=0", c, underflow); end
            end
            pix_valid = ($urandom_range(0, 3) != 0);
            pix_data = 24'($urandom);
            j = c - n - 1; h = j % 10; v = (j / 10) % 6;
            de_t = (h < 8) && (v < 4);
            lvl_before = q.size();
            e_rgb = 24'h0;
            if (de_t) begin
                if (q.size() > 0) e_rgb = q.pop_front();
                else e_uf = 1'b1;
            end
            flush = (h == 9) && (v == 5);
            if (pix_valid && lvl_before < DEPTH && !flush) q.push_back(pix_data);
            if (flush) q.delete();
            e_lvl = q.size();
            e_de = de_t;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_fifo_bounds_and_flush();
        int n, e_lvl;
        pulse_reset();
        cfg_write(3'd1, pk(0, 8191), n);
        cfg_write(3'd3, pk(0, 8191), n);
        cfg_write(3'd0, 32'h1, n);
        checks++;
        if (level !== '0 || fetch_req !== 1'b1) begin
            errors++; $display("FAIL bounds_start got=%0d/%b exp=0/1", level, fetch_req);
        end
        e_lvl = 0;
        for (int k = 0; k < 17; k++) begin
            pix_valid = 1'b1;
            pix_data = 24'($urandom);
            if (e_lvl < DEPTH) e_lvl++;
            @(posedge clk); #1;
            checks++;
            if (level !== LW'(e_lvl)) begin errors++; $display("FAIL bounds_level k=%0d got=%0d exp=%0d", k, level, e_lvl); end
            checks++;
            if (pix_ready !== (e_lvl < DEPTH)) begin
                errors++; $display("FAIL bounds_ready k=%0d got=%b exp=%b", k, pix_ready, (e_lvl < DEPTH));
            end
            checks++;
            if (fetch_req !== (e_lvl < THRESH)) begin
                errors++; $display("FAIL bounds_fetch_req k=%0d got=%b exp=%b", k, fetch_req, (e_lvl < THRESH));
            end
        end
        pix_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (level !== LW'(16)) begin errors++; $display("FAIL bounds_17th_dropped got=%0d exp=16", level); end
        cfg_write(3'd0, 32'h0, n);
        checks++;
        if (level !== '0 || pix_ready !== 1'b1 || fetch_req !== 1'b0) begin
            errors++; $display("FAIL disable_flush got=%0d/%b/%b exp=0/1/0", level, pix_ready, fetch_req);
        end
    endtask

    task automatic test_cfg_protect();
        int n, w, c, m, h, v;
        logic [2:0] e_t;
        pulse_reset();
        cfg_write(3'd1, pk(4, 7), n);
        cfg_write(3'd3, pk(2, 3), n);
        cfg_write(3'd0, 32'h1, n);
        cfg_write(3'd1, pk(1, 2), w);
        for (int k = 0; k < 48; k++) begin
            c = cyc;
            m = c - (n + 2);
            if (m < 0) begin
                e_t = 3'b011;
            end else begin
                h = m % 8; v = (m / 8) % 4;
                e_t = {(h < 4 && v < 2), (h >= 4), (v >= 2)};
            end
            checks++;
            if ({de, hblank, vblank} !== e_t) begin
                errors++; $display("FAIL cfg_protect cyc=%0d got=%b exp=%b", c, {de, hblank, vblank}, e_t);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midline();
        int n;
        logic found;
        pulse_reset();
        cfg_write(3'd1, pk(8, 9), n);
        cfg_write(3'd3, pk(4, 5), n);
        prefill16();
        cfg_write(3'd0, 32'h1, n);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (de === 1'b1 && level === LW'(5)) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midline_condition got=not_reached exp=de1_level5"); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({hsync, vsync, de, hblank, vblank} !== 5'b00011) begin
            errors++; $display("FAIL midline_reset_raster got=%b exp=00011", {hsync, vsync, de, hblank, vblank});
        end
        checks++;
        if ({R, G, B} !== 24'h0) begin errors++; $display("FAIL midline_reset_rgb got=%h exp=0", {R, G, B}); end
        checks++;
        if (level !== '0 || {underflow, pix_ready, fetch_req} !== 3'b010) begin
            errors++; $display("FAIL midline_reset_fifo got=%0d/%b exp=0/010", level, {underflow, pix_ready, fetch_req});
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_raster();
        test_underflow_clear();
        test_datapath();
        test_fifo_bounds_and_flush();
        test_cfg_protect();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
